// File: rtl/lgn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : lgn_frame_sequencer
// Brief    : Streams one binarized image into the logic-gate-network core,
//            waits for the result to settle and holds the captured arg-max.
// Revision : 1.0 - initial release
// ============================================================================
module lgn_frame_sequencer #(
    parameter int FRAME_BYTES   = 128,
    parameter int SETTLE_CYCLES = 4,
    parameter int IDX_W         = 4,
    parameter int VAL_W         = 8,
    parameter int CNT_W         = $clog2(FRAME_BYTES + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             frame_start,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             lgn_we,
    output logic [7:0]       lgn_data,
    input  logic [IDX_W-1:0] lgn_index,
    input  logic [VAL_W-1:0] lgn_value,
    output logic             result_valid,
    input  logic             result_ack,
    output logic [IDX_W-1:0] result_index,
    output logic [VAL_W-1:0] result_value,
    output logic             busy,
    output logic [CNT_W-1:0] byte_count,
    output logic [7:0]       frame_count
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_SETTLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_byte_count;
    logic [SET_W-1:0] r_settle;
    logic [7:0]       r_frame_count;
    logic             r_result_valid;
    logic [IDX_W-1:0] r_result_index;
    logic [VAL_W-1:0] r_result_value;

    logic w_accept;
    logic w_last;
    logic w_capture;

    // rst_n gates ready combinationally so no byte can be offered during reset
    assign in_ready  = rst_n & (r_state != S_SETTLE) & ~frame_start;
    assign w_accept  = in_valid & in_ready;
    assign w_last    = w_accept && (r_state == S_LOAD) &&
                       (r_byte_count == CNT_W'(FRAME_BYTES - 1));
    assign w_capture = (r_state == S_SETTLE) && !frame_start &&
                       (r_settle == SET_W'(SETTLE_CYCLES - 1));

    assign lgn_we       = w_accept;
    assign lgn_data     = in_data;
    assign busy         = (r_state == S_LOAD) || (r_state == S_SETTLE);
    assign byte_count   = r_byte_count;
    assign frame_count  = r_frame_count;
    assign result_valid = r_result_valid;
    assign result_index = r_result_index;
    assign result_value = r_result_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_byte_count  <= '0;
            r_settle      <= '0;
            r_frame_count <= '0;
        end else if (frame_start) begin
            r_state      <= S_IDLE;
            r_byte_count <= '0;
            r_settle     <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_byte_count <= CNT_W'(1);
                        r_state      <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_accept) begin
                        r_byte_count <= r_byte_count + CNT_W'(1);
                        if (w_last) begin
                            r_state  <= S_SETTLE;
                            r_settle <= '0;
                        end
                    end
                end
                S_SETTLE: begin
                    if (w_capture) begin
                        r_state       <= S_DONE;
                        r_byte_count  <= '0;
                        r_frame_count <= r_frame_count + 8'd1;
                    end else begin
                        r_settle <= r_settle + SET_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A capture overrides a coincident acknowledge; an abort freezes the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result_valid <= 1'b0;
            r_result_index <= '0;
            r_result_value <= '0;
        end else if (w_capture) begin
            r_result_valid <= 1'b1;
            r_result_index <= lgn_index;
            r_result_value <= lgn_value;
        end else if (result_ack && !frame_start) begin
            r_result_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lgn_frame_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_lgn_frame_sequencer
// Brief    : Randomized bench for lgn_frame_sequencer against an event model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lgn_frame_sequencer;

    localparam int FRAME_BYTES   = 128;
    localparam int SETTLE_CYCLES = 4;
    localparam int IDX_W         = 4;
    localparam int VAL_W         = 8;
    localparam int CNT_W         = $clog2(FRAME_BYTES + 1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             frame_start;
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic             lgn_we;
    logic [7:0]       lgn_data;
    logic [IDX_W-1:0] lgn_index;
    logic [VAL_W-1:0] lgn_value;
    logic             result_valid;
    logic             result_ack;
    logic [IDX_W-1:0] result_index;
    logic [VAL_W-1:0] result_value;
    logic             busy;
    logic [CNT_W-1:0] byte_count;
    logic [7:0]       frame_count;

    lgn_frame_sequencer #(
        .FRAME_BYTES  (FRAME_BYTES),
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .IDX_W        (IDX_W),
        .VAL_W        (VAL_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .lgn_we      (lgn_we),
        .lgn_data    (lgn_data),
        .lgn_index   (lgn_index),
        .lgn_value   (lgn_value),
        .result_valid(result_valid),
        .result_ack  (result_ack),
        .result_index(result_index),
        .result_value(result_value),
        .busy        (busy),
        .byte_count  (byte_count),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int we_cnt   = 0;

    // Reference model: bytes taken so far and cycles until the result lands
    int m_bytes;
    int m_settle_left;
    int m_frames;
    bit m_rv;
    int m_idx;
    int m_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        m_bytes = 0; m_settle_left = -1; m_frames = 0;
        m_rv = 0; m_idx = 0; m_val = 0;
    endtask

    task automatic check_regs();
        check("busy",         busy,         (m_bytes > 0) || (m_settle_left >= 0));
        check("byte_count",   byte_count,   m_bytes);
        check("frame_count",  frame_count,  m_frames % 256);
        check("result_valid", result_valid, m_rv);
        check("result_index", result_index, m_idx);
        check("result_value", result_value, m_val);
    endtask

    // One clock: inputs must already be set; returns at posedge+1
    task automatic cycle();
        bit exp_ready, exp_acc, cap;
        @(negedge clk);
        exp_ready = (m_settle_left < 0) && !frame_start;
        exp_acc   = exp_ready && in_valid;
        check("in_ready", in_ready, exp_ready);
        check("lgn_we",   lgn_we,   exp_acc);
        if (exp_acc) begin
            check("lgn_data", lgn_data, in_data);
            we_cnt++;
        end
        @(posedge clk);
        cap = 0;
        if (frame_start) begin
            m_bytes = 0;
            m_settle_left = -1;
        end else if (m_settle_left >= 0) begin
            if (m_settle_left == 1) begin
                cap = 1;
                m_rv = 1; m_idx = lgn_index; m_val = lgn_value;
                m_frames++; m_bytes = 0; m_settle_left = -1;
            end else begin
                m_settle_left--;
            end
        end else if (exp_acc) begin
            m_bytes++;
            if (m_bytes == FRAME_BYTES) m_settle_left = SETTLE_CYCLES;
        end
        if (!cap && !frame_start && result_ack) m_rv = 0;
        #1;
        check_regs();
    endtask

    // Streams until one capture; idx/val < 0 means random per cycle
    task automatic run_frame(input int valid_pct, input int idx, input int val,
                             input bit ack_at_cap, input bit alternate);
        int start_frames = m_frames;
        int n = 0;
        while (m_frames == start_frames && n < 3000) begin
            frame_start = 1'b0;
            in_data     = 8'($urandom);
            in_valid    = alternate ? n[0] : ($urandom_range(99) < valid_pct);
            lgn_index   = (idx < 0) ? IDX_W'($urandom) : IDX_W'(idx);
            lgn_value   = (val < 0) ? VAL_W'($urandom) : VAL_W'(val);
            result_ack  = ack_at_cap ? (m_settle_left == 1) : 1'b0;
            cycle();
            n++;
        end
        if (m_frames == start_frames) check("frame_timeout", 1, 0);
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0; frame_start = 1'b0; in_data = '0; in_valid = 1'b1;
        lgn_index = '0; lgn_value = '0; result_ack = 1'b0;
        #2;
        check("rst_in_ready", in_ready, 0);
        check("rst_lgn_we",   lgn_we,   0);
        check_regs();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;

        // Back-to-back frame with a held core result
        we_cnt = 0;
        run_frame(100, 7, 8'h5A, 0, 0);
        check("we_cycles_b2b", we_cnt, FRAME_BYTES);
        check("idx_b2b", result_index, 7);
        check("val_b2b", result_value, 8'h5A);
        check("frames_b2b", frame_count, 1);

        // Valid toggling every other cycle
        run_frame(0, -1, -1, 0, 1);

        // Abort after 60 bytes with a byte offered in the same cycle
        while (m_bytes < 60) begin
            in_valid = 1'b1; in_data = 8'($urandom); result_ack = 1'b0;
            cycle();
        end
        frame_start = 1'b1; in_valid = 1'b1;
        cycle();
        check("abort_bytes", byte_count, 0);
        check("abort_busy",  busy, 0);
        frame_start = 1'b0;
        run_frame(90, -1, -1, 0, 0);

        // Unacknowledged overlap, then ack on the capture edge
        run_frame(100, 3, 8'h11, 0, 0);
        run_frame(100, 9, 8'h22, 1, 0);
        check("overlap_rv",  result_valid, 1);
        check("overlap_idx", result_index, 9);

        // Fully random traffic including aborts and acks
        for (int i = 0; i < 2500; i++) begin
            frame_start = ($urandom_range(199) == 0);
            in_valid    = ($urandom_range(99) < 85);
            in_data     = 8'($urandom);
            lgn_index   = IDX_W'($urandom);
            lgn_value   = VAL_W'($urandom);
            result_ack  = frame_start ? 1'b0 : ($urandom_range(9) == 0);
            cycle();
        end

        // Asynchronous reset in the middle of settle
        frame_start = 1'b0; result_ack = 1'b0;
        while (m_settle_left != 2) begin
            in_valid = 1'b1; in_data = 8'($urandom);
            cycle();
        end
        in_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_in_ready", in_ready, 0);
        check("arst_lgn_we",   lgn_we,   0);
        check_regs();
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        cycle();

        // 256 frames from a clean count wrap frame_count back to zero
        for (int f = 0; f < 256; f++) run_frame(97, -1, -1, $urandom_range(1), 0);
        check("wrap_frame_count", frame_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
